// File: rtl/spi_flash_reader_pkg.sv
// Shared types and constants for the SPI flash read master.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        XFER = 3'd2,
        DONE = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;

    localparam logic [7:0] READ_CMD_DEF = 8'h03;

endpackage

// File: rtl/spi_flash_reader_sck_gen.sv
// SPI mode-0 clock generator: counts CLK_DIV system cycles per SCK half-period.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb,
    output logic half_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Strobes fire in the last cycle of a half-period, one cycle ahead of the SCK edge
    assign half_done = en && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_stb  = half_done && !sck;
    assign fall_stb  = half_done && sck;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (half_done) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// Word-read SPI master: one READ command + 24-bit address per request, data assembled little-endian.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int         MEM_W    = 32,
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] READ_CMD = READ_CMD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic [31:0]      addr_i,
    output logic             gnt_o,
    output logic             rvalid_o,
    output logic [MEM_W-1:0] rdata_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             spi_cs_n,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int HDR_BITS = CMD_BITS + ADDR_BITS;
    localparam int N_BITS   = HDR_BITS + MEM_W;
    localparam int BCNT_W   = $clog2(N_BITS + 1);
    localparam int GAP_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t state, state_nxt;

    logic                sck_en;
    logic                rise_stb;
    logic                fall_stb;
    logic                half_done;
    logic                addr_bad;
    logic                last_fall;
    logic [HDR_BITS-1:0] shift_q;
    logic [MEM_W-1:0]    rx_q;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;

    // Received bytes arrive first-byte-first; the first byte belongs in the low lane
    function automatic logic [MEM_W-1:0] byte_swap(input logic [MEM_W-1:0] w);
        logic [MEM_W-1:0] r;
        r = '0;
        for (int j = 0; j < MEM_W / 8; j++) begin
            r[8*j +: 8] = w[MEM_W-8-8*j +: 8];
        end
        return r;
    endfunction

    assign addr_bad = (addr_i[31:ADDR_BITS] != '0) ||
                      ((addr_i & 32'(MEM_W / 8 - 1)) != 32'd0);

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (sck_en),
        .sck      (spi_sck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .half_done(half_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_o     = 1'b0;
        busy_o    = (state != IDLE);
        sck_en    = 1'b0;
        last_fall = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    gnt_o     = 1'b1;
                    state_nxt = addr_bad ? ERR : XFER;
                end
            end
            ERR: state_nxt = IDLE;
            XFER: begin
                sck_en = 1'b1;
                if (half_done && spi_sck && (bit_cnt == BCNT_W'(1))) begin
                    last_fall = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = GAP;
            GAP: begin
                if (gap_cnt == GAP_W'(CLK_DIV - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q  <= '0;
            rx_q     <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            gap_cnt  <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            case (state)
                IDLE: begin
                    if (req_i && addr_bad) begin
                        rvalid_o <= 1'b1;
                        err_o    <= 1'b1;
                        rdata_o  <= '0;
                    end else if (req_i) begin
                        shift_q  <= {READ_CMD, addr_i[ADDR_BITS-1:0]};
                        rx_q     <= '0;
                        bit_cnt  <= BCNT_W'(N_BITS);
                        spi_cs_n <= 1'b0;
                        spi_mosi <= READ_CMD[CMD_BITS-1];
                    end
                end
                XFER: begin
                    // Only bits past the command/address header carry flash data
                    if (rise_stb && (bit_cnt <= BCNT_W'(MEM_W))) begin
                        rx_q <= {rx_q[MEM_W-2:0], spi_miso};
                    end
                    // Header drains to zero, so MOSI idles low once it is shifted out
                    if (fall_stb) begin
                        shift_q  <= {shift_q[HDR_BITS-2:0], 1'b0};
                        spi_mosi <= shift_q[HDR_BITS-2];
                        bit_cnt  <= bit_cnt - BCNT_W'(1);
                    end
                    if (last_fall) begin
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        rvalid_o <= 1'b1;
                        err_o    <= 1'b0;
                        rdata_o  <= byte_swap(rx_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomized bench for spi_flash_reader with a behavioural SPI flash and transaction-level reference.
module tb_spi_flash_reader;

    localparam int MEM_W   = 32;
    localparam int CLK_DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT with default timing
    logic             req_i = 1'b0;
    logic [31:0]      addr_i = '0;
    logic             gnt_o, rvalid_o, err_o, busy_o;
    logic [MEM_W-1:0] rdata_o;
    logic             spi_cs_n, spi_sck, spi_mosi;
    logic             spi_miso = 1'b0;

    // DUT with the fastest SCK
    logic             req1 = 1'b0;
    logic [31:0]      addr1 = '0;
    logic             gnt1, rvalid1, err1, busy1;
    logic [MEM_W-1:0] rdata1;
    logic             cs1, sck1, mosi1;
    logic             miso1 = 1'b1;

    spi_flash_reader #(.MEM_W(MEM_W), .CLK_DIV(CLK_DIV), .READ_CMD(8'h03)) u_dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_flash_reader #(.MEM_W(MEM_W), .CLK_DIV(1), .READ_CMD(8'h03)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req1), .addr_i(addr1), .gnt_o(gnt1),
        .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1), .busy_o(busy1),
        .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural flash: captures the header, serves flash_data bytes in order, MSB first
    logic [MEM_W-1:0] flash_data = '0;
    logic [31:0]      mosi_cap = '0;
    int               rise_cnt = 0, cs_fall_cnt = 0, tail_ones = 0, fbit = 0, idx = 0;
    logic             sck_prev = 1'b0, cs_prev = 1'b1;

    always @(negedge clk) begin
        if (cs_prev === 1'b1 && spi_cs_n === 1'b0) begin
            fbit = 0;
            mosi_cap = '0;
            cs_fall_cnt++;
        end
        if (sck_prev === 1'b0 && spi_sck === 1'b1 && spi_cs_n === 1'b0) begin
            rise_cnt++;
            if (fbit < 32) mosi_cap = {mosi_cap[30:0], spi_mosi};
            else if (spi_mosi !== 1'b0) tail_ones++;
            fbit++;
        end
        if (sck_prev === 1'b1 && spi_sck === 1'b0 && spi_cs_n === 1'b0 &&
            fbit >= 32 && fbit < 32 + MEM_W) begin
            idx = fbit - 32;
            spi_miso = flash_data[8*(idx/8) + 7 - (idx%8)];
        end
        sck_prev = spi_sck;
        cs_prev  = spi_cs_n;
    end

    int   rise1 = 0, high1 = 0;
    logic sck1_prev = 1'b0;
    always @(negedge clk) begin
        if (sck1_prev === 1'b0 && sck1 === 1'b1) rise1++;
        if (sck1 === 1'b1) high1++;
        sck1_prev = sck1;
    end

    function automatic bit is_bad(input logic [31:0] a);
        return (a[31:24] != 8'h00) || ((a & 32'(MEM_W/8 - 1)) != 32'd0);
    endfunction

    task automatic wait_gnt(output bit ok);
        int k = 0;
        #1;
        while (gnt_o !== 1'b1 && k < 1000) begin @(negedge clk); #1; k++; end
        ok = (gnt_o === 1'b1);
        if (!ok) check_val("gnt_timeout", 0, 1);
    endtask

    task automatic wait_rvalid(input bit scramble, output bit ok);
        int k = 0;
        #1;
        while (rvalid_o !== 1'b1 && k < 1000) begin
            @(negedge clk);
            if (scramble) begin req_i = 1'($urandom); addr_i = $urandom; end
            #1;
            k++;
        end
        ok = (rvalid_o === 1'b1);
        if (!ok) check_val("rvalid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy_o !== 1'b0 && k < 100) begin @(negedge clk); #1; k++; end
        check_val("idle_after", busy_o, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [MEM_W-1:0] data, input bit scramble);
        int unsigned tstart;
        int r0, c0, t0;
        bit bad, ok;
        bad = is_bad(addr);
        flash_data = data;
        r0 = rise_cnt; c0 = cs_fall_cnt; t0 = tail_ones;
        req_i = 1'b1; addr_i = addr;
        wait_gnt(ok);
        if (!ok) begin req_i = 1'b0; return; end
        tstart = cyc;
        @(negedge clk);
        if (scramble) begin req_i = 1'($urandom); addr_i = $urandom; end
        else req_i = 1'b0;
        wait_rvalid(scramble, ok);
        req_i = 1'b0;
        if (!ok) return;
        check_val("latency", cyc - tstart, bad ? 1 : 1 + 2*(32+MEM_W)*CLK_DIV);
        check_val("err", err_o, bad);
        check_val("rdata", rdata_o, bad ? '0 : data);
        check_val("rv_with_gnt", gnt_o, 0);
        check_val("cs_at_rv", spi_cs_n, 1);
        check_val("sck_rises", rise_cnt - r0, bad ? 0 : 32 + MEM_W);
        check_val("cs_falls", cs_fall_cnt - c0, bad ? 0 : 1);
        if (!bad) check_val("mosi_hdr", mosi_cap, {8'h03, addr[23:0]});
        check_val("mosi_tail", tail_ones - t0, 0);
        @(negedge clk); #1;
        check_val("rv_pulse", rvalid_o, 0);
        wait_idle();
    endtask

    function automatic logic [31:0] rand_good();
        return $urandom & 32'h00FF_FFFC;
    endfunction

    initial begin
        bit ok;
        int unsigned t1, d1, g2;
        int cnt;
        logic [31:0] a, b;
        logic [MEM_W-1:0] d;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_cs", spi_cs_n, 1);
        check_val("rst_sck", spi_sck, 0);
        check_val("rst_mosi", spi_mosi, 0);
        check_val("rst_rvalid", rvalid_o, 0);
        check_val("rst_rdata", rdata_o, 0);
        check_val("rst_busy", busy_o, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);

        do_read(32'h0001_2344, 32'h4433_2211, 1'b0);
        do_read(32'h0100_0000, 32'hDEAD_BEEF, 1'b0);
        do_read(32'h0000_0002, 32'hDEAD_BEEF, 1'b0);

        // Idle reset after a good read leaves rdata nonzero beforehand
        do_read(32'h0000_0010, 32'hA5C3_0F81, 1'b0);
        @(negedge clk) rst = 1'b0;
        #1;
        check_val("idle_rst_rdata", rdata_o, 0);
        check_val("idle_rst_cs", spi_cs_n, 1);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(3) == 0) begin
                a = $urandom;
                if (!is_bad(a)) a[24] = 1'b1;
            end else begin
                a = rand_good();
            end
            do_read(a, $urandom, 1'($urandom));
        end

        // Back-to-back with req held high
        a = rand_good(); b = rand_good();
        d = $urandom;
        flash_data = d;
        req_i = 1'b1; addr_i = a;
        wait_gnt(ok);
        t1 = cyc;
        @(negedge clk) addr_i = b;
        wait_rvalid(1'b0, ok);
        d1 = cyc;
        check_val("b2b_lat", d1 - t1, 1 + 2*(32+MEM_W)*CLK_DIV);
        check_val("b2b_rdata0", rdata_o, d);
        check_val("b2b_mosi0", mosi_cap, {8'h03, a[23:0]});
        d = $urandom;
        flash_data = d;
        @(negedge clk);
        wait_gnt(ok);
        g2 = cyc;
        check_val("b2b_gnt_gap", 32'(g2 - d1 >= CLK_DIV), 1);
        check_val("b2b_cs_high", 32'(g2 + 1 - d1 >= CLK_DIV), 1);
        @(negedge clk) req_i = 1'b0;
        wait_rvalid(1'b0, ok);
        check_val("b2b_rdata1", rdata_o, d);
        check_val("b2b_mosi1", mosi_cap, {8'h03, b[23:0]});
        wait_idle();

        // Reset in the middle of a transfer
        flash_data = $urandom;
        req_i = 1'b1; addr_i = rand_good();
        wait_gnt(ok);
        @(negedge clk) req_i = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("xfer_rst_cs", spi_cs_n, 1);
        check_val("xfer_rst_sck", spi_sck, 0);
        check_val("xfer_rst_rvalid", rvalid_o, 0);
        check_val("xfer_rst_rdata", rdata_o, 0);
        @(negedge clk) rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (rvalid_o === 1'b1) cnt++;
        end
        check_val("no_stale_rv", cnt, 0);
        check_val("post_rst_cs", spi_cs_n, 1);

        // CLK_DIV=1 instance: MISO held high
        begin
            int r0, h0, k;
            r0 = rise1; h0 = high1;
            @(negedge clk);
            req1 = 1'b1; addr1 = rand_good();
            #1;
            k = 0;
            while (gnt1 !== 1'b1 && k < 100) begin @(negedge clk); #1; k++; end
            t1 = cyc;
            @(negedge clk) req1 = 1'b0;
            #1;
            k = 0;
            while (rvalid1 !== 1'b1 && k < 400) begin @(negedge clk); #1; k++; end
            check_val("div1_lat", cyc - t1, 129);
            check_val("div1_rises", rise1 - r0, 64);
            check_val("div1_high", high1 - h0, 64);
            check_val("div1_cs", cs1, 1);
            check_val("div1_err", err1, 0);
            check_val("div1_rdata", rdata1, {MEM_W{1'b1}});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
